// File: rtl/trap_csr_unit_pkg.sv
// Shared constants for the machine-mode CSR file and trap generator:
// CSR addresses, excepttype codes, mcause values and bit positions.
package trap_csr_unit_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  // Codes handed to the pipeline controller
  typedef enum logic [31:0] {
    EXC_NONE    = 32'h0000_0000,
    EXC_INT     = 32'h0000_0001,
    EXC_ECALL   = 32'h0000_0008,
    EXC_ILLEGAL = 32'h0000_000a,
    EXC_MRET    = 32'h0000_000e
  } exc_e;

  // mcause values written on trap entry
  localparam logic [31:0] MCAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_TMR     = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] MCAUSE_ECALL   = 32'h0000_000B;

  // Bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIE_MTIE_BIT     = 7;

  // Only machine mode exists, so MPP is hard-wired to 2'b11
  localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;

  localparam logic [31:0] MTVEC_RST_DEFAULT = 32'h0000_0020;

  // Assemble the architectural mstatus view from the two stored bits
  function automatic logic [31:0] mstatus_pack(input logic mpie, input logic mie);
    logic [31:0] v;
    v = MSTATUS_MPP_RO;
    v[MSTATUS_MPIE_BIT] = mpie;
    v[MSTATUS_MIE_BIT]  = mie;
    return v;
  endfunction

endpackage

// File: rtl/trap_csr_unit_irq_sync.sv
// Multi-flop synchronizer bringing the asynchronous external interrupt
// level into the clk domain. SYNC_STAGES must be at least 2.
module trap_csr_unit_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the flop chain; stage 0 is the metastable one
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap generator beside the MEM stage.
// Reads are write-forwarded; trap/mret field updates override a
// same-cycle CSR write on the fields they touch.
module trap_csr_unit
  import trap_csr_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST   = MTVEC_RST_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_ecall_i,
  input  logic        mem_illegal_i,
  input  logic        mem_mret_i,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mtvec_o
);

  // Stored CSR state
  logic        mst_mie_q, mst_mpie_q;
  logic        mst_mie_d, mst_mpie_d;
  logic        meie_q, mtie_q;
  logic        meie_d, mtie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mcycle_q, mcycle_d;
  logic [31:0] mcycleh_q, mcycleh_d;

  // Forwarded view: stored value with this cycle's WB write applied
  logic        mst_mie_fwd, mst_mpie_fwd;
  logic        meie_fwd, mtie_fwd;
  logic [31:0] mtvec_fwd, mscratch_fwd, mepc_fwd, mcause_fwd;
  logic [31:0] mcycle_fwd, mcycleh_fwd;

  logic        sync_ext;
  logic        int_ext, int_tmr;
  exc_e        exc;
  logic        trap_take, mret_take;
  logic [31:0] trap_cause;
  logic        mcycle_carry;

  trap_csr_unit_irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(ext_irq_i),
    .sync_o (sync_ext)
  );

  // Apply the WB write (with field masking) on top of the stored CSRs
  always_comb begin
    mst_mie_fwd  = mst_mie_q;
    mst_mpie_fwd = mst_mpie_q;
    meie_fwd     = meie_q;
    mtie_fwd     = mtie_q;
    mtvec_fwd    = mtvec_q;
    mscratch_fwd = mscratch_q;
    mepc_fwd     = mepc_q;
    mcause_fwd   = mcause_q;
    mcycle_fwd   = mcycle_q;
    mcycleh_fwd  = mcycleh_q;
    if (csr_we_i) begin
      case (csr_waddr_i)
        CSR_MSTATUS: begin
          mst_mie_fwd  = csr_wdata_i[MSTATUS_MIE_BIT];
          mst_mpie_fwd = csr_wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          meie_fwd = csr_wdata_i[MIE_MEIE_BIT];
          mtie_fwd = csr_wdata_i[MIE_MTIE_BIT];
        end
        CSR_MTVEC:    mtvec_fwd    = {csr_wdata_i[31:2], 2'b00};
        CSR_MSCRATCH: mscratch_fwd = csr_wdata_i;
        CSR_MEPC:     mepc_fwd     = {csr_wdata_i[31:2], 2'b00};
        CSR_MCAUSE:   mcause_fwd   = csr_wdata_i;
        CSR_MCYCLE:   mcycle_fwd   = csr_wdata_i;
        CSR_MCYCLEH:  mcycleh_fwd  = csr_wdata_i;
        default: ;
      endcase
    end
  end

  // EX-stage read mux over the forwarded view; unmapped addresses read 0
  always_comb begin
    csr_rdata_o = 32'h0;
    case (csr_raddr_i)
      CSR_MSTATUS: csr_rdata_o = mstatus_pack(mst_mpie_fwd, mst_mie_fwd);
      CSR_MIE: begin
        csr_rdata_o[MIE_MEIE_BIT] = meie_fwd;
        csr_rdata_o[MIE_MTIE_BIT] = mtie_fwd;
      end
      CSR_MTVEC:    csr_rdata_o = mtvec_fwd;
      CSR_MSCRATCH: csr_rdata_o = mscratch_fwd;
      CSR_MEPC:     csr_rdata_o = mepc_fwd;
      CSR_MCAUSE:   csr_rdata_o = mcause_fwd;
      CSR_MIP: begin
        csr_rdata_o[MIE_MEIE_BIT] = sync_ext;
        csr_rdata_o[MIE_MTIE_BIT] = tmr_irq_i;
      end
      CSR_MCYCLE:   csr_rdata_o = mcycle_fwd;
      CSR_MCYCLEH:  csr_rdata_o = mcycleh_fwd;
      default: ;
    endcase
  end

  assign csr_mepc_o  = mepc_fwd;
  assign csr_mtvec_o = mtvec_fwd;

  // Prioritise interrupt > illegal > ecall > mret; bubbles take nothing
  always_comb begin
    int_ext    = sync_ext  & meie_fwd & mst_mie_fwd;
    int_tmr    = tmr_irq_i & mtie_fwd & mst_mie_fwd;
    exc        = EXC_NONE;
    trap_cause = MCAUSE_ECALL;
    if (!rst && mem_valid_i) begin
      if (int_ext) begin
        exc        = EXC_INT;
        trap_cause = MCAUSE_EXT;
      end else if (int_tmr) begin
        exc        = EXC_INT;
        trap_cause = MCAUSE_TMR;
      end else if (mem_illegal_i) begin
        exc        = EXC_ILLEGAL;
        trap_cause = MCAUSE_ILLEGAL;
      end else if (mem_ecall_i) begin
        exc        = EXC_ECALL;
        trap_cause = MCAUSE_ECALL;
      end else if (mem_mret_i) begin
        exc        = EXC_MRET;
      end
    end
    trap_take = (exc == EXC_INT) || (exc == EXC_ILLEGAL) || (exc == EXC_ECALL);
    mret_take = (exc == EXC_MRET);
  end

  assign excepttype_o = exc;

  // Next state: written values first, then trap/mret overrides on top
  always_comb begin
    mst_mie_d  = mst_mie_fwd;
    mst_mpie_d = mst_mpie_fwd;
    meie_d     = meie_fwd;
    mtie_d     = mtie_fwd;
    mtvec_d    = mtvec_fwd;
    mscratch_d = mscratch_fwd;
    mepc_d     = mepc_fwd;
    mcause_d   = mcause_fwd;
    if (trap_take) begin
      mepc_d     = mem_pc_i & ~32'h3;
      mcause_d   = trap_cause;
      mst_mpie_d = mst_mie_fwd;
      mst_mie_d  = 1'b0;
    end else if (mret_take) begin
      mst_mie_d  = mst_mpie_fwd;
      mst_mpie_d = 1'b1;
    end
  end

  // 64-bit cycle counter; a written half skips its increment but the
  // other half still takes the carry out of the low word
  always_comb begin
    mcycle_carry = (mcycle_q == 32'hFFFF_FFFF);
    mcycle_d     = mcycle_q + 32'd1;
    mcycleh_d    = mcycleh_q + {31'd0, mcycle_carry};
    if (csr_we_i && csr_waddr_i == CSR_MCYCLE) begin
      mcycle_d = csr_wdata_i;
    end
    if (csr_we_i && csr_waddr_i == CSR_MCYCLEH) begin
      mcycleh_d = csr_wdata_i;
    end
  end

  // CSR state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mcycle_q   <= 32'h0;
      mcycleh_q  <= 32'h0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      meie_q     <= meie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      mcycleh_q  <= mcycleh_d;
    end
  end

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed, table-driven bench for trap_csr_unit. Each table row is one
// clock cycle: inputs are driven just after the rising edge and outputs
// are compared on the falling edge.
module tb_trap_csr_unit;

  logic        clk;
  logic        rst;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_ecall_i;
  logic        mem_illegal_i;
  logic        mem_mret_i;
  logic        ext_irq_i;
  logic        tmr_irq_i;
  logic [31:0] excepttype_o;
  logic [31:0] csr_mepc_o;
  logic [31:0] csr_mtvec_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic        valid;
    logic [31:0] pc;
    logic        ecall;
    logic        ill;
    logic        mret;
    logic        ext;
    logic        tmr;
    logic [31:0] e_exc;
    logic [31:0] e_rdata;
    logic [31:0] e_mepc;
    logic [31:0] e_mtvec;
  } vec_t;

  vec_t tbl[$];

  trap_csr_unit dut (
    .clk          (clk),
    .rst          (rst),
    .csr_raddr_i  (csr_raddr_i),
    .csr_rdata_o  (csr_rdata_o),
    .csr_we_i     (csr_we_i),
    .csr_waddr_i  (csr_waddr_i),
    .csr_wdata_i  (csr_wdata_i),
    .mem_valid_i  (mem_valid_i),
    .mem_pc_i     (mem_pc_i),
    .mem_ecall_i  (mem_ecall_i),
    .mem_illegal_i(mem_illegal_i),
    .mem_mret_i   (mem_mret_i),
    .ext_irq_i    (ext_irq_i),
    .tmr_irq_i    (tmr_irq_i),
    .excepttype_o (excepttype_o),
    .csr_mepc_o   (csr_mepc_o),
    .csr_mtvec_o  (csr_mtvec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic we, input logic [11:0] waddr, input logic [31:0] wdata,
    input logic [11:0] raddr, input logic valid, input logic [31:0] pc,
    input logic ecall, input logic ill, input logic mret,
    input logic ext, input logic tmr,
    input logic [31:0] e_exc, input logic [31:0] e_rdata,
    input logic [31:0] e_mepc, input logic [31:0] e_mtvec);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
    v.valid = valid; v.pc = pc; v.ecall = ecall; v.ill = ill;
    v.mret = mret; v.ext = ext; v.tmr = tmr;
    v.e_exc = e_exc; v.e_rdata = e_rdata; v.e_mepc = e_mepc; v.e_mtvec = e_mtvec;
    return v;
  endfunction

  task automatic check(input string name, input string tag, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s[%0d]: got %08h expected %08h", name, tag, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    csr_we_i      = v.we;
    csr_waddr_i   = v.waddr;
    csr_wdata_i   = v.wdata;
    csr_raddr_i   = v.raddr;
    mem_valid_i   = v.valid;
    mem_pc_i      = v.pc;
    mem_ecall_i   = v.ecall;
    mem_illegal_i = v.ill;
    mem_mret_i    = v.mret;
    ext_irq_i     = v.ext;
    tmr_irq_i     = v.tmr;
  endtask

  // One cycle: drive, compare on the falling edge, advance past the next rise
  task automatic step(input vec_t v, input string tag, input int idx);
    drive(v);
    @(negedge clk);
    check("excepttype", tag, idx, excepttype_o, v.e_exc);
    check("rdata",      tag, idx, csr_rdata_o,  v.e_rdata);
    check("mepc",       tag, idx, csr_mepc_o,   v.e_mepc);
    check("mtvec",      tag, idx, csr_mtvec_o,  v.e_mtvec);
    $display("%s[%0d] raddr=%03h exc=%08h rdata=%08h mepc=%08h mtvec=%08h",
             tag, idx, v.raddr, excepttype_o, csr_rdata_o, csr_mepc_o, csr_mtvec_o);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: we waddr wdata raddr valid pc ecall ill mret ext tmr | exc rdata mepc mtvec
    tbl.push_back(mk(0, 0, 0, 12'hB00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h20));
    tbl.push_back(mk(0, 0, 0, 12'hB00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 0, 32'h20));
    tbl.push_back(mk(0, 0, 0, 12'hB00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 0, 32'h20));
    tbl.push_back(mk(0, 0, 0, 12'h305, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0, 32'h20));
    tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1800, 0, 32'h20));
    tbl.push_back(mk(0, 0, 0, 12'h341, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h20));
    tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h20));
    tbl.push_back(mk(0, 0, 0, 12'h7FF, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h20));
    // mie write masked to MEIE|MTIE, mstatus MIE=1, mtvec low bits dropped, unmapped write ignored
    tbl.push_back(mk(1, 12'h304, 32'hFFFFFFFF, 12'h304, 0, 0, 0, 0, 0, 0, 0, 0, 32'h880, 0, 32'h20));
    tbl.push_back(mk(1, 12'h300, 32'h8, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 0, 32'h20));
    tbl.push_back(mk(1, 12'h305, 32'h103, 12'h305, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h100));
    tbl.push_back(mk(1, 12'h7FF, 32'h1234, 12'h7FF, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100));
    // external interrupt through the two-flop synchronizer
    tbl.push_back(mk(0, 0, 0, 12'h344, 1, 32'h104, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h344, 1, 32'h104, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h344, 1, 32'h104, 0, 0, 0, 1, 0, 32'h1, 32'h800, 0, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h341, 0, 0, 0, 0, 0, 1, 0, 0, 32'h104, 32'h104, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h342, 1, 32'h300, 0, 0, 0, 1, 0, 0, 32'h8000000B, 32'h104, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1880, 32'h104, 32'h100));
    // illegal beats ecall
    tbl.push_back(mk(0, 0, 0, 12'h300, 1, 32'h200, 1, 1, 0, 0, 0, 32'ha, 32'h1880, 32'h104, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 32'h200, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1800, 32'h200, 32'h100));
    // ecall with misaligned pc
    tbl.push_back(mk(0, 0, 0, 12'h341, 1, 32'h20E, 1, 0, 0, 0, 0, 32'h8, 32'h200, 32'h200, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 32'hB, 32'h20C, 32'h100));
    // mret with MPIE=1 MIE=0
    tbl.push_back(mk(1, 12'h300, 32'h80, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1880, 32'h20C, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h341, 1, 32'h400, 0, 0, 1, 0, 0, 32'he, 32'h20C, 32'h20C, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1888, 32'h20C, 32'h100));
    // timer interrupt
    tbl.push_back(mk(0, 0, 0, 12'h344, 1, 32'h500, 0, 0, 0, 0, 1, 32'h1, 32'h80, 32'h20C, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80000007, 32'h500, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1880, 32'h500, 32'h100));
    // mepc write in the same cycle as mret is forwarded
    tbl.push_back(mk(1, 12'h341, 32'h300, 12'h341, 1, 32'h404, 0, 0, 1, 0, 0, 32'he, 32'h300, 32'h300, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1888, 32'h300, 32'h100));
    // mstatus write clearing MIE with an ecall: MPIE takes the written MIE
    tbl.push_back(mk(1, 12'h300, 32'h0, 12'h300, 1, 32'h600, 1, 0, 0, 0, 0, 32'h8, 32'h1800, 32'h300, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1800, 32'h600, 32'h100));
    // mcause write overridden by a same-cycle illegal trap
    tbl.push_back(mk(1, 12'h342, 32'h55, 12'h342, 1, 32'h700, 0, 1, 0, 0, 0, 32'ha, 32'h55, 32'h600, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 32'h700, 32'h100));
    tbl.push_back(mk(1, 12'h340, 32'hDEADBEEF, 12'h340, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h700, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h340, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h700, 32'h100));
    // pending external interrupt held across bubbles
    tbl.push_back(mk(1, 12'h300, 32'h8, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h700, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h344, 0, 32'h800, 0, 1, 0, 1, 0, 0, 32'h0, 32'h700, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h344, 0, 32'h800, 0, 0, 0, 1, 0, 0, 32'h0, 32'h700, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h344, 0, 32'h800, 0, 0, 0, 1, 0, 0, 32'h800, 32'h700, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h344, 0, 32'h800, 0, 0, 0, 1, 0, 0, 32'h800, 32'h700, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h344, 1, 32'h800, 0, 0, 0, 1, 0, 32'h1, 32'h800, 32'h700, 32'h100));
    tbl.push_back(mk(0, 0, 0, 12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000000B, 32'h800, 32'h100));

    // Reset: excepttype forced to 0 even with a valid illegal instruction
    rst = 1'b1;
    drive(mk(0, 0, 0, 12'h305, 1, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("excepttype", "reset", 0, excepttype_o, 32'h0);
    check("rdata",      "reset", 0, csr_rdata_o,  32'h20);
    check("mepc",       "reset", 0, csr_mepc_o,   32'h0);
    check("mtvec",      "reset", 0, csr_mtvec_o,  32'h20);
    $display("reset[0] exc=%08h rdata=%08h mepc=%08h mtvec=%08h",
             excepttype_o, csr_rdata_o, csr_mepc_o, csr_mtvec_o);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i], "row", i);
    end

    // mcycle wrap carrying into mcycleh
    step(mk(1, 12'hB80, 32'h5, 12'hB80, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5, 32'h800, 32'h100), "wrap", 0);
    step(mk(1, 12'hB00, 32'hFFFFFFFF, 12'hB00, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h800, 32'h100), "wrap", 1);
    step(mk(0, 0, 0, 12'hB80, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5, 32'h800, 32'h100), "wrap", 2);
    step(mk(0, 0, 0, 12'hB80, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6, 32'h800, 32'h100), "wrap", 3);
    step(mk(0, 0, 0, 12'hB00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 32'h800, 32'h100), "wrap", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
